// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder/subtractor:
// parameter legality and group-count derivation.
package cla_pkg;

  function automatic bit cla_width_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

  function automatic int cla_num_groups(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead block: flat sum-of-products in-group carries
// plus the group propagate/generate used by the next lookahead level.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p_i,
  input  logic [GROUP-1:0] g_i,
  input  logic             c_i,
  output logic             pg_o,
  output logic             gg_o,
  output logic [GROUP-1:0] carry_o
);

  // carry_o[i] is the carry into bit i, each term expanded rather than rippled
  always_comb begin
    logic term;
    term    = 1'b0;
    pg_o    = &p_i;
    gg_o    = 1'b0;
    carry_o = '0;
    for (int j = 0; j < GROUP; j++) begin
      term = g_i[j];
      for (int k = j + 1; k < GROUP; k++) term = term & p_i[k];
      gg_o = gg_o | term;
    end
    for (int i = 0; i < GROUP; i++) begin
      term = c_i;
      for (int k = 0; k < i; k++) term = term & p_i[k];
      carry_o[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g_i[j];
        for (int k = j + 1; k < i; k++) term = term & p_i[k];
        carry_o[i] = carry_o[i] | term;
      end
    end
  end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined WIDTH-bit CLA adder/subtractor with valid/ready on
// both sides; S1 holds per-bit and per-group P/G, S2 holds the result.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = cla_num_groups(WIDTH, GROUP);

  typedef logic [NG:0] group_carry_t;

  if (!cla_width_ok(WIDTH, GROUP)) begin : gWidthCheck
    $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of GROUP");
  end

  logic             s1Valid_q;
  logic [WIDTH-1:0] s1Prop_q, s1Gen_q;
  logic [NG-1:0]    s1GrpProp_q, s1GrpGen_q;
  logic             s1Cin_q;

  logic [WIDTH-1:0] s1Prop_d, s1Gen_d, bEff;
  logic [NG-1:0]    s1GrpProp_d, s1GrpGen_d;
  logic             s1Cin_d;

  logic             s2Valid_q, s2Cout_q, s2Ovf_q, s2Zero_q;
  logic [WIDTH-1:0] s2Sum_q;
  logic             s2Cout_d, s2Ovf_d, s2Zero_d;
  logic [WIDTH-1:0] s2Sum_d;

  group_carry_t     groupCarry;
  logic [WIDTH-1:0] bitCarry;
  logic [WIDTH-1:0] unusedS1Carry;
  logic [NG-1:0]    unusedS2GrpProp, unusedS2GrpGen;

  logic s1Advance, s2Advance;

  assign s2Advance = !s2Valid_q || out_ready;
  assign s1Advance = !s1Valid_q || s2Advance;
  assign in_ready  = s1Advance;

  assign bEff     = b ^ {WIDTH{sub}};
  assign s1Prop_d = a ^ bEff;
  assign s1Gen_d  = a & bEff;
  assign s1Cin_d  = cin ^ sub;

  for (genvar g = 0; g < NG; g++) begin : gLevel1
    cla_group #(.GROUP(GROUP)) uGroupS1 (
      .p_i     (s1Prop_d[g*GROUP +: GROUP]),
      .g_i     (s1Gen_d[g*GROUP +: GROUP]),
      .c_i     (1'b0),
      .pg_o    (s1GrpProp_d[g]),
      .gg_o    (s1GrpGen_d[g]),
      .carry_o (unusedS1Carry[g*GROUP +: GROUP])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
    end else if (s1Advance) begin
      s1Valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && s1Advance && in_valid) begin
      s1Prop_q    <= s1Prop_d;
      s1Gen_q     <= s1Gen_d;
      s1GrpProp_q <= s1GrpProp_d;
      s1GrpGen_q  <= s1GrpGen_d;
      s1Cin_q     <= s1Cin_d;
    end
  end

  // Second-level lookahead: every group carry is a flat product sum of c0
  always_comb begin
    logic term;
    term          = 1'b0;
    groupCarry    = '0;
    groupCarry[0] = s1Cin_q;
    for (int k = 0; k < NG; k++) begin
      term = s1Cin_q;
      for (int j = 0; j <= k; j++) term = term & s1GrpProp_q[j];
      groupCarry[k+1] = term;
      for (int j = 0; j <= k; j++) begin
        term = s1GrpGen_q[j];
        for (int m = j + 1; m <= k; m++) term = term & s1GrpProp_q[m];
        groupCarry[k+1] = groupCarry[k+1] | term;
      end
    end
  end

  for (genvar g = 0; g < NG; g++) begin : gLevel2
    cla_group #(.GROUP(GROUP)) uGroupS2 (
      .p_i     (s1Prop_q[g*GROUP +: GROUP]),
      .g_i     (s1Gen_q[g*GROUP +: GROUP]),
      .c_i     (groupCarry[g]),
      .pg_o    (unusedS2GrpProp[g]),
      .gg_o    (unusedS2GrpGen[g]),
      .carry_o (bitCarry[g*GROUP +: GROUP])
    );
  end

  assign s2Sum_d  = s1Prop_q ^ bitCarry;
  assign s2Cout_d = groupCarry[NG];
  assign s2Ovf_d  = bitCarry[WIDTH-1] ^ groupCarry[NG];
  assign s2Zero_d = (s2Sum_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Sum_q   <= '0;
      s2Cout_q  <= 1'b0;
      s2Ovf_q   <= 1'b0;
      s2Zero_q  <= 1'b0;
    end else if (s2Advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Sum_q  <= s2Sum_d;
        s2Cout_q <= s2Cout_d;
        s2Ovf_q  <= s2Ovf_d;
        s2Zero_q <= s2Zero_d;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign sum       = s2Sum_q;
  assign cout      = s2Cout_q;
  assign ovf       = s2Ovf_q;
  assign zero      = s2Zero_q;

endmodule
